// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with wrap-bit full/empty detection, occupancy count,
// almost-full/empty thresholds, sticky overflow/underflow flags and optional FWFT read mode.
module sync_fifo_param #(
   parameter int DATA_W    = 11,
   parameter int ADDR_W    = 4,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              wr_full,
   output logic              rd_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];
   if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH >= AFULL_TH) begin : g_bad_params
      $error("sync_fifo_param: illegal AFULL_TH/AEMPTY_TH combination");
   end
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d, head;
   logic              dv_q, dv_d, ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
   assign head         = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign rd_empty     = wr_ptr_q == rd_ptr_q;
   assign wr_full      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = count >= AF_TH;
   assign almost_empty = count <= AE_TH;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   // FWFT shows the head word combinationally; standard mode presents a registered copy
   assign data_out     = FWFT != 0 ? head : dout_q;
   assign data_valid   = FWFT != 0 ? ~rd_empty : dv_q;
   always_comb begin
      wr_acc   = wr_en & ~wr_full;
      rd_acc   = rd_en & ~rd_empty;
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
      dout_d   = rd_acc ? head : dout_q;
      dv_d     = rd_acc;
      ovf_d    = (wr_en & wr_full) | (ovf_q & ~clr_err);
      unf_d    = (rd_en & rd_empty) | (unf_q & ~clr_err);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
   end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench with a scoreboard queue for standard-mode reads and a FWFT instance.
module tb_sync_fifo_param;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [10:0] data_in = '0;
   logic [10:0] data_out;
   logic        data_valid, wr_full, rd_empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  count;
   logic        wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
   logic [10:0] din1 = '0;
   logic [10:0] dout1;
   logic        dv1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [4:0]  cnt1;
   int          tests = 0, fails = 0;
   logic [10:0] exp_q [$];
   sync_fifo_param #(.DATA_W(11), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .data_valid(data_valid), .wr_full(wr_full), .rd_empty(rd_empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err));
   sync_fifo_param #(.DATA_W(11), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
      .data_out(dout1), .data_valid(dv1), .wr_full(full1), .rd_empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(unf1), .clr_err(clr1));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input logic w, input logic [10:0] d, input logic r, input logic c);
      wr_en = w; data_in = d; rd_en = r; clr_err = c;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask
   task automatic wr(input logic [10:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask
   task automatic rd(input logic [10:0] e);
      exp_q.push_back(e);
      step(1'b0, '0, 1'b1, 1'b0);
   endtask
   task automatic step1(input logic w, input logic [10:0] d, input logic r);
      wr1 = w; din1 = d; rd1 = r;
      @(posedge clk); #1;
      wr1 = 1'b0; rd1 = 1'b0;
   endtask
   // monitor: every standard-mode data_valid must match the next expected word
   always @(negedge clk) begin
      if (rst_n && data_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_read: got 0x%0h expected no valid data at %0t", data_out, $time);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               fails++;
               $display("FAIL read_data: got 0x%0h expected 0x%0h at %0t", data_out, e, $time);
            end
         end
      end
   end
   initial begin
      #3;
      chk("rst_count", count, 0);
      chk("rst_empty", rd_empty, 1);
      chk("rst_full", wr_full, 0);
      chk("rst_aempty", almost_empty, 1);
      chk("rst_afull", almost_full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_fwft_empty", empty1, 1);
      chk("rst_fwft_dv", dv1, 0);
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 16; i++) begin
         wr(11'(i));
         chk("fill_count", count, i);
         chk("fill_afull", almost_full, i >= 12);
         chk("fill_aempty", almost_empty, i <= 2);
         chk("fill_full", wr_full, i == 16);
      end
      wr(11'h7FF);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      for (int i = 1; i <= 16; i++) begin
         rd(11'(i));
         chk("drain_count", count, 16 - i);
      end
      chk("drain_empty", rd_empty, 1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("unf_set", underflow, 1);
      chk("unf_hold_dout", data_out, 11'h010);
      chk("unf_dv", data_valid, 0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_ovf", overflow, 0);
      chk("clr_unf", underflow, 0);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 10; i++) wr(11'(11'h100 + r * 10 + i));
         chk("wrap_count_hi", count, 10);
         for (int i = 0; i < 10; i++) rd(11'(11'h100 + r * 10 + i));
         chk("wrap_count_lo", count, 0);
      end
      for (int i = 0; i < 5; i++) wr(11'(11'h300 + i));
      exp_q.push_back(11'h300);
      step(1'b1, 11'h305, 1'b1, 1'b0);
      chk("rw_mid_count", count, 5);
      for (int i = 6; i <= 16; i++) wr(11'(11'h300 + i));
      chk("rw_full_pre", wr_full, 1);
      exp_q.push_back(11'h301);
      step(1'b1, 11'h3FF, 1'b1, 1'b0);
      chk("rw_full_count", count, 15);
      chk("rw_full_ovf", overflow, 1);
      for (int i = 2; i <= 16; i++) rd(11'(11'h300 + i));
      chk("rw_full_drained", rd_empty, 1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 11'h0AB, 1'b1, 1'b0);
      chk("rw_empty_count", count, 1);
      chk("rw_empty_unf", underflow, 1);
      rd(11'h0AB);
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) wr(11'(11'h400 + i));
      step(1'b1, 11'h555, 1'b0, 1'b1);
      chk("set_beats_clr", overflow, 1);
      chk("set_beats_clr_count", count, 16);
      for (int i = 0; i < 9; i++) rd(11'(11'h400 + i));
      chk("pre_rst_count", count, 7);
      chk("pre_rst_ovf", overflow, 1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", rd_empty, 1);
      chk("arst_ovf", overflow, 0);
      chk("arst_dout", data_out, 0);
      chk("arst_dv", data_valid, 0);
      #2; rst_n = 1'b1;
      @(posedge clk); #1;
      step1(1'b1, 11'h2AA, 1'b0);
      chk("fwft_dout", dout1, 11'h2AA);
      chk("fwft_dv", dv1, 1);
      step1(1'b0, '0, 1'b1);
      chk("fwft_pop_empty", empty1, 1);
      chk("fwft_pop_dv", dv1, 0);
      step1(1'b1, 11'h055, 1'b0);
      step1(1'b1, 11'h0AA, 1'b0);
      chk("fwft_head", dout1, 11'h055);
      step1(1'b0, '0, 1'b1);
      chk("fwft_next", dout1, 11'h0AA);
      chk("fwft_count", cnt1, 1);
      @(posedge clk); #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
